// File: rtl/rblwe_poly_engine.sv
// rblwe_poly_engine: small polynomial engine over 1-bit coefficients.
// Operations: negacyclic POLYMUL (one coefficient per cycle), POLYADD (sum mod 7),
// BINADD / ADDE (XOR combinations), and an optional LFSR-based SAMPLE that also
// refreshes the internal H register.
// Optional feature macro: RBLWE_SAMPLE_EN (builds the SAMPLE datapath and LFSR).
module rblwe_poly_engine #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [4:0]   opcode,
  input  logic [N-1:0] d_poly,
  input  logic [N-1:0] b_poly,
  input  logic [N-1:0] g_poly,
  input  logic [N-1:0] h_poly,
  input  logic         h_sel,
  output logic [N-1:0] w_poly,
  output logic         valid,
  output logic         done,
  output logic         busy,
  output logic         err
);

  localparam int IW = $clog2(N);
  localparam int DW = IW + 1;
  localparam int SW = N + 1;
  localparam int NB = N / 8;

  localparam logic [4:0] OP_POLYMUL = 5'b00001;
  localparam logic [4:0] OP_POLYADD = 5'b00010;
  localparam logic [4:0] OP_BINADD  = 5'b00011;
  localparam logic [4:0] OP_SAMPLE  = 5'b00100;
  localparam logic [4:0] OP_ADDE    = 5'b00110;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_MUL,
    S_SAMPLE,
    S_FINISH
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   d_q, d_d;
  logic [N-1:0]   b_q, b_d;
  logic [N-1:0]   g_q, g_d;
  logic [N-1:0]   h_q, h_d;
  logic [4:0]     op_q, op_d;
  logic [IW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   acc_q, acc_d;
  logic [N-1:0]   w_q, w_d;
  logic           valid_q, valid_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic [N-1:0]   h_int;

`ifdef RBLWE_SAMPLE_EN
  logic [N-1:0]   h_int_q, h_int_d;
  logic [7:0]     lfsr_q, lfsr_d;
  logic           lfsr_fb;

  assign h_int   = h_int_q;
  assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
`else
  // Without the sampler nothing can ever load internal H.
  assign h_int = '0;
`endif

  // Negacyclic product term for coefficient cnt_q: D[j] & B[(i-j) mod N].
  // The sign of wrapped terms is irrelevant because only the LSB survives.
  logic [N-1:0] mul_terms;
  logic         mul_coef;

  for (genvar gi = 0; gi < N; gi++) begin : g_term
    logic [DW-1:0] diff;
    logic [IW-1:0] b_idx;
    assign diff  = {1'b0, cnt_q} - DW'(gi);
    assign b_idx = diff[DW-1] ? IW'(diff + DW'(N)) : diff[IW-1:0];
    assign mul_terms[gi] = d_q[gi] & b_q[b_idx];
  end

  assign mul_coef = ^mul_terms;

  // POLYADD reduces the full carry-out sum, so the modulus sees bit N.
  logic [N:0] add_sum;
  logic [2:0] add_mod;
  assign add_sum = {1'b0, d_q} + {1'b0, g_q};
  assign add_mod = 3'(add_sum % SW'(7));

  // Next-state and datapath: operands latch only on accept in IDLE.
  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    b_d     = b_q;
    g_d     = g_q;
    h_d     = h_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    w_d     = w_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef RBLWE_SAMPLE_EN
    h_int_d = h_int_q;
    lfsr_d  = lfsr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          d_d   = d_poly;
          b_d   = b_poly;
          g_d   = g_poly;
          h_d   = h_sel ? h_int : h_poly;
          op_d  = opcode;
          cnt_d = '0;
          acc_d = '0;
`ifdef RBLWE_SAMPLE_EN
          lfsr_d = 8'hFF;
`endif
          case (opcode)
            OP_POLYMUL: state_d = S_MUL;
`ifdef RBLWE_SAMPLE_EN
            OP_SAMPLE:  state_d = S_SAMPLE;
`endif
            default:    state_d = S_EXEC;
          endcase
        end
      end
      S_EXEC: begin
        valid_d = 1'b1;
        state_d = S_FINISH;
        case (op_q)
          OP_POLYADD: w_d = N'(add_mod);
          OP_BINADD:  w_d = d_q ^ h_q;
          OP_ADDE:    w_d = d_q ^ g_q ^ h_q;
          default: begin
            w_d   = '0;
            err_d = 1'b1;
          end
        endcase
      end
      S_MUL: begin
        // Coefficients enter at the top, so coefficient 0 ends at bit 0.
        acc_d = {mul_coef, acc_q[N-1:1]};
        if (cnt_q == IW'(N - 1)) begin
          w_d     = acc_d;
          valid_d = 1'b1;
          state_d = S_FINISH;
        end else begin
          cnt_d = cnt_q + IW'(1);
        end
      end
      S_SAMPLE: begin
`ifdef RBLWE_SAMPLE_EN
        acc_d  = (acc_q << 8) | N'(lfsr_q);
        lfsr_d = {lfsr_fb, lfsr_q[7:1]};
        if (cnt_q == IW'(NB - 1)) begin
          w_d     = acc_d;
          h_int_d = acc_d;
          valid_d = 1'b1;
          state_d = S_FINISH;
        end else begin
          cnt_d = cnt_q + IW'(1);
        end
`else
        state_d = S_IDLE;
`endif
      end
      S_FINISH: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      d_q     <= '0;
      b_q     <= '0;
      g_q     <= '0;
      h_q     <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      w_q     <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      b_q     <= b_d;
      g_q     <= g_d;
      h_q     <= h_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      w_q     <= w_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

`ifdef RBLWE_SAMPLE_EN
  // Sampler state: internal H changes only at SAMPLE completion or reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_int_q <= '0;
      lfsr_q  <= 8'hFF;
    end else begin
      h_int_q <= h_int_d;
      lfsr_q  <= lfsr_d;
    end
  end
`endif

  assign w_poly = w_q;
  assign valid  = valid_q;
  assign done   = done_q;
  assign err    = err_q;
  assign busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_rblwe_poly_engine.sv
// Directed bench for rblwe_poly_engine (N=32). Expected values are hand-derived.
// Latency is counted in rising edges from the edge that accepts start.
module tb_rblwe_poly_engine;

  logic        clk;
  logic        reset;
  logic        start;
  logic [4:0]  opcode;
  logic [31:0] d_poly, b_poly, g_poly, h_poly;
  logic        h_sel;
  logic [31:0] w_poly;
  logic        valid, done, busy, err;

  int checks = 0;
  int errors = 0;

  rblwe_poly_engine #(.N(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .opcode (opcode),
    .d_poly (d_poly),
    .b_poly (b_poly),
    .g_poly (g_poly),
    .h_poly (h_poly),
    .h_sel  (h_sel),
    .w_poly (w_poly),
    .valid  (valid),
    .done   (done),
    .busy   (busy),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation, wait (bounded) for valid, check result and done pulse.
  task automatic run_op(input string tag, input logic [4:0] op,
                        input logic [31:0] d, input logic [31:0] b,
                        input logic [31:0] g, input logic [31:0] h, input logic hs,
                        input logic [31:0] exp_w, input logic exp_err, input int exp_lat);
    int lat;
    @(negedge clk);
    opcode = op; d_poly = d; b_poly = b; g_poly = g; h_poly = h; h_sel = hs;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    $display("txn %s op=%b w=%h err=%b lat=%0d", tag, op, w_poly, err, lat);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_w"}, 64'(w_poly), 64'(exp_w));
    check({tag, "_err"}, 64'(err), 64'(exp_err));
    check({tag, "_busy"}, 64'(busy), 64'd1);
    check({tag, "_done_early"}, 64'(done), 64'd0);
    @(posedge clk); #1;
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_valid_off"}, 64'(valid), 64'd0);
    check({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int lat;
    int seen;
    reset = 1'b1; start = 1'b0; opcode = '0; h_sel = 1'b0;
    d_poly = '0; b_poly = '0; g_poly = '0; h_poly = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_w", 64'(w_poly), 64'd0);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op("add_5_4",   5'b00010, 32'd5, 32'd0, 32'd4, 32'd0, 1'b0, 32'd2, 1'b0, 2);
    run_op("add_wrap",  5'b00010, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'd0, 1'b0, 32'd4, 1'b0, 2);
    run_op("binadd",    5'b00011, 32'hF0F0_1234, 32'd0, 32'd0, 32'h0FF0_0001, 1'b0,
           32'hFF00_1235, 1'b0, 2);
    run_op("adde",      5'b00110, 32'hAAAA_0000, 32'd0, 32'h0000_5555, 32'h1111_1111, 1'b0,
           32'hBBBB_4444, 1'b0, 2);
    run_op("mul_1",     5'b00001, 32'h0000_0001, 32'h8000_0000, 32'd0, 32'd0, 1'b0,
           32'h8000_0000, 1'b0, 33);
    run_op("mul_wrap",  5'b00001, 32'h0000_0002, 32'h8000_0000, 32'd0, 32'd0, 1'b0,
           32'h0000_0001, 1'b0, 33);
    run_op("mul_sq",    5'b00001, 32'h0000_0003, 32'h0000_0003, 32'd0, 32'd0, 1'b0,
           32'h0000_0005, 1'b0, 33);
    run_op("illegal7",  5'b00111, 32'h1234_5678, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b1, 2);
    run_op("illegal0",  5'b00000, 32'h1234_5678, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b1, 2);

`ifdef RBLWE_SAMPLE_EN
    run_op("sample",    5'b00100, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'hFF7F_BF5F, 1'b0, 5);
    run_op("bin_hint",  5'b00011, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'h1234_5678, 1'b1,
           32'h0080_40A0, 1'b0, 2);
`else
    run_op("sample_off", 5'b00100, 32'h1234_5678, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b1, 2);
    run_op("bin_hint",  5'b00011, 32'h1234_5678, 32'd0, 32'd0, 32'hFFFF_0000, 1'b1,
           32'h1234_5678, 1'b0, 2);
`endif

    // start held high through a POLYMUL while operands/opcode change underneath.
    @(negedge clk);
    opcode = 5'b00001; d_poly = 32'h1; b_poly = 32'h8000_0000; h_sel = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    opcode = 5'b00010; d_poly = 32'd5; g_poly = 32'd4;
    lat = 1;
    while (valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    $display("txn hold_mul w=%h lat=%0d", w_poly, lat);
    check("hold_mul_lat", 64'(lat), 64'd33);
    check("hold_mul_w", 64'(w_poly), 64'h8000_0000);
    @(posedge clk); #1;
    check("hold_mul_done", 64'(done), 64'd1);
    @(posedge clk); #1;
    start = 1'b0;
    check("hold_reaccept_busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    $display("txn hold_add w=%h valid=%b", w_poly, valid);
    check("hold_add_valid", 64'(valid), 64'd1);
    check("hold_add_w", 64'(w_poly), 64'd2);
    @(posedge clk); #1;
    check("hold_add_done", 64'(done), 64'd1);

    // Reset during MUL cycle 10: w_poly currently holds 2 from the last add.
    @(negedge clk);
    opcode = 5'b00001; d_poly = 32'h3; b_poly = 32'h3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    $display("txn mul_abort w=%h busy=%b valid=%b", w_poly, busy, valid);
    check("abort_valid", 64'(valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_w", 64'(w_poly), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (valid === 1'b1 || done === 1'b1) seen++;
    end
    check("abort_no_pulse", 64'(seen), 64'd0);

    // Reset has priority over start.
    @(negedge clk);
    opcode = 5'b00010; d_poly = 32'd1; g_poly = 32'd1;
    reset = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    check("rst_prio_busy", 64'(busy), 64'd0);
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    seen = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (valid === 1'b1 || busy === 1'b1) seen++;
    end
    $display("txn rst_prio seen=%0d", seen);
    check("rst_prio_quiet", 64'(seen), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
